// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default sizing for the FIFO write arbiter
// Purpose: arbiter state enum and default NUM_REQ / DATA_WIDTH / BURST_MAX values.
// Ports:   none (package).
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int FIFO_ARB_NUM_REQ    = 4;
    localparam int FIFO_ARB_DATA_WIDTH = 8;
    localparam int FIFO_ARB_BURST_MAX  = 4;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// rtl/fifo_arb_rr_pick.sv - combinational rotating-priority picker
// Purpose: find the first set bit of req searching upward from (rr_ptr+1) mod N.
// Ports:   req    in  N   request flags
//          rr_ptr in  IW  index of the previous owner
//          any    out 1   at least one request present
//          idx    out IW  chosen index (0 when any=0)
module fifo_arb_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    int          j;
    logic [IW-1:0] jj;

    // Walk the offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        jj  = '0;
        for (int k = N; k >= 1; k--) begin
            j  = (int'(rr_ptr) + k) % N;
            jj = IW'(j);
            if (req[jj]) begin
                any = 1'b1;
                idx = jj;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter in front of a FIFO write port
// Purpose: grant one requester at a time, forward its beats to the FIFO until
//          req_last or BURST_MAX beats, then rotate priority.
// Ports:   aclk, areset (async, active-high)
//          req_valid/req_data/req_last in, req_ready out  (per requester)
//          fifo_full in, fifo_wr_en/fifo_wr_data out
//          grant_id out (current or last owner), busy out (grant held)
//          stat_sel in / stat_cnt out only with FIFO_WR_ARB_STATS_EN defined
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = FIFO_ARB_NUM_REQ,
    parameter int DATA_WIDTH = FIFO_ARB_DATA_WIDTH,
    parameter int BURST_MAX  = FIFO_ARB_BURST_MAX
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
`ifdef FIFO_WR_ARB_STATS_EN
    input  logic [$clog2(NUM_REQ)-1:0]    stat_sel,
    output logic [15:0]                   stat_cnt,
`endif
    output logic                          busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_MAX + 1);

    arb_state_t          state;
    logic [IW-1:0]       rr_ptr;
    logic [CW-1:0]       beat_cnt;
    logic [CW-1:0]       beat_nxt;

    logic                pick_any;
    logic [IW-1:0]       pick_idx;

    logic [NUM_REQ-1:0]  gnt_onehot;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                xfer;
    logic                burst_end;

    fifo_arb_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    // Mux the granted requester's lane; other lanes never reach the outputs.
    always_comb begin
        gnt_onehot = '0;
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IW'(i)) begin
                gnt_onehot[i] = 1'b1;
                sel_valid     = req_valid[i];
                sel_last      = req_last[i];
                sel_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy         = (state == ARB_BURST);
    assign req_ready    = (busy && !fifo_full) ? gnt_onehot : '0;
    assign xfer         = busy && !fifo_full && sel_valid;
    assign fifo_wr_en   = xfer;
    assign fifo_wr_data = sel_data;
    assign beat_nxt     = beat_cnt + CW'(1);
    assign burst_end    = xfer && (sel_last || (beat_nxt == CW'(BURST_MAX)));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= ARB_IDLE;
            rr_ptr   <= IW'(NUM_REQ - 1);
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        state    <= ARB_BURST;
                    end
                end
                default: begin
                    if (xfer) begin
                        beat_cnt <= beat_nxt;
                    end
                    if (burst_end) begin
                        rr_ptr <= grant_id;
                        state  <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] beat_stat [NUM_REQ];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                beat_stat[i] <= '0;
            end
            stat_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer && gnt_onehot[i] && (beat_stat[i] != 16'hFFFF)) begin
                    beat_stat[i] <= beat_stat[i] + 16'd1;
                end
            end
            stat_cnt <= beat_stat[stat_sel];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BM = 4;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_ready;
    logic            fifo_full = 1'b0;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [1:0]      stat_sel = '0;
    logic [15:0]     stat_cnt;
`endif

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
`ifdef FIFO_WR_ARB_STATS_EN
        .stat_sel     (stat_sel),
        .stat_cnt     (stat_cnt),
`endif
        .busy         (busy)
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: who owns the port, who owned it last, beats so far.
    bit m_busy;
    int m_owner;
    int m_prev;
    int m_beats;

    // DUT-observed bookkeeping for sequence checks.
    int  grant_log[$];
    bit  prev_busy_seen;
    int  wr_seen;

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_prev  = NR - 1;
        m_beats = 0;
        prev_busy_seen = 0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        model_reset();
    endtask

    // One clock: apply inputs, compare against the model, advance the model.
    task automatic cyc(input logic [NR-1:0] v, input logic [NR-1:0] l,
                       input logic f, input logic [NR*DW-1:0] d);
        logic [NR-1:0] e_rdy;
        bit            e_wr;
        req_valid = v;
        req_last  = l;
        fifo_full = f;
        req_data  = d;
        #2;
        e_rdy = (m_busy && !f) ? NR'(1 << m_owner) : '0;
        e_wr  = m_busy && v[m_owner] && !f;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("grant_id", 32'(grant_id), 32'(m_owner));
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
        if (e_wr) chk("fifo_wr_data", 32'(fifo_wr_data), 32'(d[m_owner*DW +: DW]));
        if (busy && !prev_busy_seen) grant_log.push_back(int'(grant_id));
        prev_busy_seen = busy;
        if (fifo_wr_en) wr_seen++;
        if (!m_busy) begin
            for (int k = 1; k <= NR; k++) begin
                if (v[(m_prev + k) % NR]) begin
                    m_owner = (m_prev + k) % NR;
                    m_busy  = 1;
                    m_beats = 0;
                    break;
                end
            end
        end else if (e_wr) begin
            m_beats++;
            if (l[m_owner] || m_beats == BM) begin
                m_busy = 0;
                m_prev = m_owner;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    typedef struct {
        logic [NR-1:0] v;
        logic [NR-1:0] l;
        logic          f;
        logic          e_busy;
        logic [1:0]    e_gid;
        logic [NR-1:0] e_rdy;
        logic          e_wr;
        logic [DW-1:0] e_d;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic f, logic b,
                                logic [1:0] g, logic [3:0] r, logic w, logic [7:0] d);
        vec_t t;
        t.v = v; t.l = l; t.f = f; t.e_busy = b; t.e_gid = g;
        t.e_rdy = r; t.e_wr = w; t.e_d = d;
        return t;
    endfunction

    localparam logic [31:0] TBL_DATA = 32'h44332211;

    initial begin
        logic [NR-1:0] rv;
        logic [NR-1:0] rl;

        // Requester 2 alone (3 beats, last on 3rd), requester 1 hold while 3 waits,
        // then requester 3 stalled by fifo_full for one cycle.
        tbl[0]  = mk(4'b0100, 4'b0000, 0, 0, 2'd0, 4'b0000, 0, 8'h00);
        tbl[1]  = mk(4'b0100, 4'b0000, 0, 1, 2'd2, 4'b0100, 1, 8'h33);
        tbl[2]  = mk(4'b0100, 4'b0000, 0, 1, 2'd2, 4'b0100, 1, 8'h33);
        tbl[3]  = mk(4'b0100, 4'b0100, 0, 1, 2'd2, 4'b0100, 1, 8'h33);
        tbl[4]  = mk(4'b0000, 4'b0000, 0, 0, 2'd2, 4'b0000, 0, 8'h00);
        tbl[5]  = mk(4'b0010, 4'b0000, 0, 0, 2'd2, 4'b0000, 0, 8'h00);
        tbl[6]  = mk(4'b0010, 4'b0000, 0, 1, 2'd1, 4'b0010, 1, 8'h22);
        tbl[7]  = mk(4'b1000, 4'b0000, 0, 1, 2'd1, 4'b0010, 0, 8'h00);
        tbl[8]  = mk(4'b1000, 4'b0000, 0, 1, 2'd1, 4'b0010, 0, 8'h00);
        tbl[9]  = mk(4'b1000, 4'b0000, 0, 1, 2'd1, 4'b0010, 0, 8'h00);
        tbl[10] = mk(4'b1010, 4'b0010, 0, 1, 2'd1, 4'b0010, 1, 8'h22);
        tbl[11] = mk(4'b1000, 4'b0000, 0, 0, 2'd1, 4'b0000, 0, 8'h00);
        tbl[12] = mk(4'b1000, 4'b0000, 1, 1, 2'd3, 4'b0000, 0, 8'h00);
        tbl[13] = mk(4'b1000, 4'b1000, 0, 1, 2'd3, 4'b1000, 1, 8'h44);
        tbl[14] = mk(4'b0000, 4'b0000, 0, 0, 2'd3, 4'b0000, 0, 8'h00);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            req_valid = tbl[i].v;
            req_last  = tbl[i].l;
            fifo_full = tbl[i].f;
            req_data  = TBL_DATA;
            #2;
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_grant", i), 32'(grant_id), 32'(tbl[i].e_gid));
            chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_wr_en", i), 32'(fifo_wr_en), 32'(tbl[i].e_wr));
            if (tbl[i].e_wr) chk($sformatf("tbl%0d_data", i), 32'(fifo_wr_data), 32'(tbl[i].e_d));
            @(posedge aclk);
            #1;
        end

        // All four requesting, never last: grants rotate 0,1,2,3,0 with 4 beats each.
        do_reset();
        grant_log.delete();
        wr_seen = 0;
        for (int i = 0; i < 25; i++) cyc(4'b1111, 4'b0000, 0, 32'($urandom));
        chk("rr_grant_count", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < grant_log.size() && i < 5; i++)
            chk($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(i % 4));
        chk("rr_beats", 32'(wr_seen), 32'd20);

        // fifo_full for 5 cycles after beat 2: burst ends after exactly 2 more beats.
        do_reset();
        wr_seen = 0;
        cyc(4'b0001, 4'b0000, 0, 32'hA5A5A5A5);
        cyc(4'b0001, 4'b0000, 0, 32'h000000B1);
        cyc(4'b0001, 4'b0000, 0, 32'h000000B2);
        for (int i = 0; i < 5; i++) cyc(4'b0001, 4'b0000, 1, 32'h000000EE);
        cyc(4'b0001, 4'b0000, 0, 32'h000000B3);
        cyc(4'b0001, 4'b0000, 0, 32'h000000B4);
        chk("stall_busy_after", 32'(busy), 32'd0);
        chk("stall_beats", 32'(wr_seen), 32'd4);

        // Reset in the middle of a requester-3 burst, then 4'b1010 -> requester 1.
        do_reset();
        cyc(4'b1000, 4'b0000, 0, 32'h11223344);
        cyc(4'b1000, 4'b0000, 0, 32'h11223344);
        req_valid = 4'b1000;
        #2;
        chk("mid_pre_wr_en", 32'(fifo_wr_en), 32'd1);
        do_reset();
        cyc(4'b1010, 4'b0000, 0, 32'h55667788);
        chk("post_rst_grant", 32'(grant_id), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rv = NR'($urandom_range(0, 15));
            rl = NR'($urandom & $urandom);
            cyc(rv, rl, ($urandom_range(0, 4) == 0), 32'($urandom));
        end

`ifdef FIFO_WR_ARB_STATS_EN
        do_reset();
        stat_sel = 2'd0;
        wr_seen = 0;
        req_valid = 4'b0001;
        req_last = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < 90000 && wr_seen < 70000; i++) begin
            @(negedge aclk);
            if (fifo_wr_en) wr_seen++;
        end
        req_valid = '0;
        chk("stat_beats_sent", 32'(wr_seen), 32'd70000);
        repeat (3) @(posedge aclk);
        #1;
        chk("stat_sat", 32'(stat_cnt), 32'd65535);
        stat_sel = 2'd1;
        @(posedge aclk);
        #1;
        chk("stat_other", 32'(stat_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing the FIFO write port (range 2..16).
REQ-002 Parameter DATA_WIDTH, default 8, is the width of one write beat.
REQ-003 Parameter BURST_MAX, default 4, is the maximum number of beats per grant (range 1..255).
REQ-004 aclk  in  1  is the single clock; all state changes on its rising edge.
REQ-005 areset  in  1  is the reset; it is asynchronous and active-high.
REQ-006 req_valid  in  NUM_REQ  carries per-requester beat-valid flags.
REQ-007 req_data  in  NUM_REQ*DATA_WIDTH  carries per-requester beats; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  in  NUM_REQ  flags the per-requester final beat of a burst.
REQ-009 req_ready  out  NUM_REQ  carries per-requester beat-accept flags.
REQ-010 fifo_full  in  1  is the FIFO write-side full flag.
REQ-011 fifo_wr_en  out  1  is the FIFO write strobe.
REQ-012 fifo_wr_data  out  DATA_WIDTH  is the FIFO write data.
REQ-013 grant_id  out  $clog2(NUM_REQ)  is the index of the current or last owner.
REQ-014 busy  out  1  is high while a grant is held.

Function
REQ-015 The block SHALL implement two states, IDLE and BURST; busy SHALL equal (state==BURST).
REQ-016 In IDLE with any req_valid high, the block SHALL pick the first valid index searching upward from (rr_ptr+1) mod NUM_REQ, register it into grant_id, clear beat_cnt, and enter BURST next cycle (1-cycle arbitration latency).
REQ-017 In IDLE, req_ready SHALL be all zero and fifo_wr_en SHALL be 0.
REQ-018 In BURST, req_ready[grant_id] SHALL equal !fifo_full; all other req_ready bits SHALL be 0.
REQ-019 A beat transfers when req_valid[grant_id] && req_ready[grant_id]; in that same cycle fifo_wr_en SHALL be 1 and fifo_wr_data SHALL equal the granted slice of req_data (combinational, zero latency).
REQ-020 fifo_wr_en SHALL never be 1 while fifo_full is 1 (no overflow generated by this block).
REQ-021 beat_cnt (width $clog2(BURST_MAX+1)) SHALL increment on each transfer.
REQ-022 The burst SHALL end on a transfer with req_last[grant_id]=1 or when that transfer makes beat_cnt reach BURST_MAX; on end, rr_ptr<=grant_id and state<=IDLE next cycle.
REQ-023 In BURST with req_valid[grant_id]=0, the grant SHALL be held (no timeout, no preemption).
REQ-024 fifo_full SHALL stall only; beat_cnt, grant_id and state SHALL hold while stalled.
REQ-025 Changes on non-granted requesters' inputs SHALL have no effect during BURST.

Reset
REQ-026 On areset high: state=IDLE, rr_ptr=NUM_REQ-1, grant_id=0, beat_cnt=0, busy=0, req_ready=0, fifo_wr_en=0, immediately and without a clock.
REQ-027 Reset mid-burst SHALL abandon the burst; the first grant after release SHALL go to the lowest valid index.

Configuration
REQ-028 With FIFO_WR_ARB_STATS_EN defined, the block SHALL add input stat_sel ($clog2(NUM_REQ)) and output stat_cnt (16), plus one 16-bit saturating accepted-beat counter per requester, cleared by areset; stat_cnt SHALL be the registered counter[stat_sel] (1-cycle latency).
REQ-029 Without FIFO_WR_ARB_STATS_EN, these ports and counters SHALL be absent.

Structure
REQ-030 Package fifo_arb_pkg SHALL hold the state enum (ARB_IDLE, ARB_BURST) and the default NUM_REQ/DATA_WIDTH/BURST_MAX constants.
REQ-031 The rotating priority search SHALL be a combinational sub-module fifo_arb_rr_pick (inputs req, rr_ptr; outputs any, idx).

Verification
REQ-032 After reset, req_valid=4'b1111, all req_last=0, fifo_full=0 -> grants 0,1,2,3,0 in turn, 4 beats each; IDLE cycle between grants.
REQ-033 Requester 2 alone, 3 beats with req_last on beat 3 -> 3 fifo_wr_en pulses with requester 2 data, then grant_id=2, busy=0.
REQ-034 fifo_full=1 for 5 cycles mid-burst (after beat 2) -> no fifo_wr_en, beat_cnt holds at 2, burst resumes and ends after 2 more beats.
REQ-035 Granted requester 1 drops valid for 3 cycles while requester 3 requests -> grant stays 1, req_ready[3]=0 throughout.
REQ-036 areset asserted at beat 2 of a requester-3 burst -> outputs clear asynchronously; after release with 4'b1010 valid, requester 1 granted first.
REQ-037 With FIFO_WR_ARB_STATS_EN, requester 0 sends 70000 beats -> stat_cnt (stat_sel=0) saturates at 65535.
